netbus_combine_pkt: RTL and testbench

- Registered, packet-aware successor to the NetBus field combiner.
- Accepts per-beat payload on a valid/ready slave port and packs each beat into the NetBus word {DATAX,STRB,CMD,DID,SID,FIRST,LAST}.
- Generates FIRST/LAST from a beat length captured on the header beat, and holds CMD/DID/SID constant for the whole packet.
- Sits between a NetBus master's payload source and the bus fabric; a full-throughput skid stage decouples backpressure.

---
 rtl/netbus_pkg.sv | 48 ++++
 rtl/netbus_skid_buf.sv | 59 +++++
 rtl/netbus_combine_pkt.sv | 124 ++++++++++++
 tb/tb_netbus_combine_pkt.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/netbus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : netbus_pkg
// Purpose : Shared NetBus constants, word width helper and field offsets.
// Revision: 1.0 - initial release
// ============================================================================
package netbus_pkg;

    localparam int CMD_W  = 2;
    localparam int FLAG_W = 2;

    localparam logic [CMD_W-1:0] CMD_READ   = 2'd0;
    localparam logic [CMD_W-1:0] CMD_WRITE  = 2'd1;
    localparam logic [CMD_W-1:0] CMD_POSTED = 2'd2;
    localparam logic [CMD_W-1:0] CMD_MSG    = 2'd3;

    // Word layout, LSB upwards: LAST, FIRST, SID, DID, CMD, STRB, DATAX
    localparam int LAST_OFF  = 0;
    localparam int FIRST_OFF = 1;
    localparam int SID_OFF   = FLAG_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } fsm_state_t;

    function automatic int netbus_word_w(input int data_width, input int id_width);
        return 9*data_width + 2*id_width + 4;
    endfunction

    function automatic int did_off(input int id_width);
        return SID_OFF + id_width;
    endfunction

    function automatic int cmd_off(input int id_width);
        return SID_OFF + 2*id_width;
    endfunction

    function automatic int strb_off(input int id_width);
        return cmd_off(id_width) + CMD_W;
    endfunction

    function automatic int datax_off(input int data_width, input int id_width);
        return strb_off(id_width) + data_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/netbus_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : netbus_skid_buf
// Purpose : Two-entry valid/ready register slice with registered s_ready.
// Revision: 1.0 - initial release
// ============================================================================
module netbus_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic             r_m_valid;
    logic             r_sk_valid;
    logic [WIDTH-1:0] r_m_data;
    logic [WIDTH-1:0] r_sk_data;
    logic             w_acc;
    logic             w_load;

    assign s_ready = ~r_sk_valid;
    assign w_acc   = s_valid & ~r_sk_valid;
    assign w_load  = ~r_m_valid | m_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

    // A beat can only reach the skid while main is stalled, so the skid
    // is always older than any beat arriving on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid  <= 1'b0;
            r_sk_valid <= 1'b0;
            r_m_data   <= '0;
            r_sk_data  <= '0;
        end else if (w_load) begin
            if (r_sk_valid) begin
                r_m_valid  <= 1'b1;
                r_m_data   <= r_sk_data;
                r_sk_valid <= 1'b0;
            end else begin
                r_m_valid <= w_acc;
                if (w_acc) begin
                    r_m_data <= s_data;
                end
            end
        end else if (w_acc) begin
            r_sk_valid <= 1'b1;
            r_sk_data  <= s_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/netbus_combine_pkt.sv
`default_nettype none
// ============================================================================
// Module  : netbus_combine_pkt
// Purpose : Packs payload beats into NetBus words with packet FIRST/LAST.
// Revision: 1.0 - initial release
// ============================================================================
module netbus_combine_pkt
    import netbus_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ID_WIDTH   = 5,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [8*DATA_WIDTH-1:0]             s_datax,
    input  logic [DATA_WIDTH-1:0]               s_strb,
    input  logic [CMD_W-1:0]                    s_cmd,
    input  logic [ID_WIDTH-1:0]                 s_did,
    input  logic [ID_WIDTH-1:0]                 s_sid,
    input  logic [LEN_WIDTH-1:0]                s_len,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [9*DATA_WIDTH+2*ID_WIDTH+3:0]  m_data,
    output logic                                busy
);

    localparam int c_WORD_W = netbus_word_w(DATA_WIDTH, ID_WIDTH);

    fsm_state_t           r_state;
    fsm_state_t           w_state_nxt;
    logic [LEN_WIDTH-1:0] r_rem;
    logic [LEN_WIDTH-1:0] w_rem_nxt;
    logic [CMD_W-1:0]     r_cmd;
    logic [ID_WIDTH-1:0]  r_did;
    logic [ID_WIDTH-1:0]  r_sid;
    logic [CMD_W-1:0]     w_cmd;
    logic [ID_WIDTH-1:0]  w_did;
    logic [ID_WIDTH-1:0]  w_sid;
    logic                 w_first;
    logic                 w_last;
    logic                 w_latch;
    logic                 w_acc;
    logic [c_WORD_W-1:0]  w_word;

    assign w_acc = s_valid & s_ready;
    assign busy  = (r_state == ST_BODY);

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_first     = 1'b0;
        w_last      = 1'b0;
        w_latch     = 1'b0;
        w_cmd       = r_cmd;
        w_did       = r_did;
        w_sid       = r_sid;
        case (r_state)
            ST_IDLE: begin
                w_first = 1'b1;
                w_last  = (s_len == '0);
                w_cmd   = s_cmd;
                w_did   = s_did;
                w_sid   = s_sid;
                if (w_acc) begin
                    w_latch = 1'b1;
                    if (!w_last) begin
                        w_state_nxt = ST_BODY;
                        w_rem_nxt   = s_len;
                    end
                end
            end
            ST_BODY: begin
                w_last = (r_rem == LEN_WIDTH'(1));
                if (w_acc) begin
                    w_rem_nxt = r_rem - LEN_WIDTH'(1);
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_cmd   <= '0;
            r_did   <= '0;
            r_sid   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (w_latch) begin
                r_cmd <= s_cmd;
                r_did <= s_did;
                r_sid <= s_sid;
            end
        end
    end

    assign w_word = {s_datax, s_strb, w_cmd, w_did, w_sid, w_first, w_last};

    netbus_skid_buf #(
        .WIDTH (c_WORD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (w_word),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_netbus_combine_pkt.sv
`default_nettype none
// ============================================================================
// Module  : tb_netbus_combine_pkt
// Purpose : Self-checking bench for netbus_combine_pkt with a packet-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_netbus_combine_pkt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_datax = '0;
    logic [3:0]  s_strb = '0;
    logic [1:0]  s_cmd = '0;
    logic [4:0]  s_did = '0;
    logic [4:0]  s_sid = '0;
    logic [7:0]  s_len = '0;
    logic        m_valid;
    logic        m_ready;
    logic [49:0] m_data;
    logic        busy;

    logic        s_valid1 = 1'b0;
    logic        s_ready1;
    logic [63:0] s_datax1 = '0;
    logic [7:0]  s_strb1 = '0;
    logic [1:0]  s_cmd1 = '0;
    logic [5:0]  s_did1 = '0;
    logic [5:0]  s_sid1 = '0;
    logic [7:0]  s_len1 = '0;
    logic        m_valid1;
    logic [87:0] m_data1;
    logic        busy1;

    always #5 clk = ~clk;

    netbus_combine_pkt u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_datax(s_datax), .s_strb(s_strb), .s_cmd(s_cmd), .s_did(s_did),
        .s_sid(s_sid), .s_len(s_len), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .busy(busy)
    );

    netbus_combine_pkt #(.DATA_WIDTH(8), .ID_WIDTH(6), .LEN_WIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1),
        .s_datax(s_datax1), .s_strb(s_strb1), .s_cmd(s_cmd1), .s_did(s_did1),
        .s_sid(s_sid1), .s_len(s_len1), .m_valid(m_valid1), .m_ready(1'b1),
        .m_data(m_data1), .busy(busy1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int xfers  = 0;
    int maxq   = 0;
    int rdy_mode = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Packet-level reference: expected words queue, position within packet
    logic [49:0] q[$];
    bit          in_pkt = 0;
    int          idx = 0;
    int          plen = 0;
    logic [1:0]  h_cmd;
    logic [4:0]  h_did, h_sid;
    bit          prev_stall = 0;
    logic [49:0] prev_data;

    always @(negedge clk) begin
        logic [49:0] w;
        if (rst) begin
            chk("rst_mvalid", m_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mdata", m_data, 0);
            q.delete();
            in_pkt = 0;
            prev_stall = 0;
        end else begin
            chk("mvalid_vs_occupancy", m_valid, q.size() != 0);
            chk("sready_vs_occupancy", s_ready, q.size() < 2);
            chk("busy_vs_packet", busy, in_pkt);
            if (prev_stall) begin
                chk("stall_mvalid", m_valid, 1);
                chk("stall_mdata", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) chk("unexpected_word", m_data, 0);
                else begin
                    w = q.pop_front();
                    chk("word", m_data, w);
                end
                xfers++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (s_valid && s_ready) begin
                if (!in_pkt) begin
                    h_cmd = s_cmd; h_did = s_did; h_sid = s_sid;
                    plen = int'(s_len); idx = 0;
                end
                w = {s_datax, s_strb, h_cmd, h_did, h_sid, idx == 0, idx == plen};
                q.push_back(w);
                if (idx == plen) in_pkt = 0;
                else begin in_pkt = 1; idx++; end
            end
            if (q.size() > maxq) maxq = q.size();
        end
    end

    task automatic send(input logic [7:0] len, input logic [1:0] cmd, input logic [4:0] did,
                        input logic [4:0] sid, input logic [31:0] dx, input logic [3:0] st);
        bit acc = 0;
        s_valid = 1'b1; s_len = len; s_cmd = cmd; s_did = did; s_sid = sid;
        s_datax = dx; s_strb = st;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        chk("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] dx;
        logic [3:0]  st;
        logic [1:0]  cmd;
        logic [4:0]  did;
        logic [4:0]  sid;
        logic [49:0] exp;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int x0, c0, len;
        tbl[0] = '{32'hA5A5_0001, 4'hF, 2'd2, 5'd3, 5'd7, 50'h2_9694_0007_E19F};
        tbl[1] = '{32'h0000_0000, 4'h0, 2'd0, 5'd0, 5'd0, {32'h0, 4'h0, 2'd0, 5'd0, 5'd0, 2'b11}};
        tbl[2] = '{32'hFFFF_FFFF, 4'h5, 2'd3, 5'd31, 5'd31, {32'hFFFF_FFFF, 4'h5, 2'd3, 5'd31, 5'd31, 2'b11}};
        tbl[3] = '{32'h1234_5678, 4'hA, 2'd1, 5'd16, 5'd1, {32'h1234_5678, 4'hA, 2'd1, 5'd16, 5'd1, 2'b11}};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_sready", s_ready, 1);
        chk("reset_mvalid", m_valid, 0);
        chk("reset_mdata", m_data, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            send(8'd0, tbl[i].cmd, tbl[i].did, tbl[i].sid, tbl[i].dx, tbl[i].st);
            @(negedge clk);
            chk("single_mvalid", m_valid, 1);
            chk("single_word", m_data, tbl[i].exp);
            chk("single_busy", busy, 0);
            @(posedge clk);
            #1;
        end
        drain();

        send(8'd3, 2'd1, 5'd3, 5'd5, 32'h1000_0001, 4'hF);
        chk("pkt4_busy_b1", busy, 1);
        for (int b = 2; b <= 4; b++) begin
            send(8'd0, 2'd3, 5'd9, 5'd20, 32'h1000_0000 + b, 4'h3);
            chk("pkt4_busy", busy, b < 4);
        end
        drain();

        maxq = 0;
        fork
            for (int b = 0; b < 4; b++) send(8'd3, 2'd2, 5'd4, 5'd6, 32'hB000_0000 + b, 4'hC);
            begin
                @(posedge clk);
                rdy_mode = 2;
                repeat (3) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();
        chk("bp_max_buffered", maxq, 2);

        x0 = xfers;
        c0 = cyc;
        for (int b = 0; b < 256; b++) send(8'd255, 2'd1, 5'd2, 5'd3, b, 4'hF);
        send(8'd0, 2'd0, 5'd11, 5'd12, 32'hCAFE_F00D, 4'h1);
        chk("throughput_cycles", cyc - c0, 257);
        drain();
        chk("throughput_words", xfers - x0, 257);

        rdy_mode = 1;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(0, 6);
            for (int b = 0; b <= len; b++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send(8'(len), 2'($urandom), 5'($urandom), 5'($urandom), $urandom, 4'($urandom));
            end
        end
        rdy_mode = 0;
        drain();

        send(8'd4, 2'd2, 5'd1, 5'd2, 32'hD000_0001, 4'hF);
        send(8'd4, 2'd2, 5'd1, 5'd2, 32'hD000_0002, 4'hF);
        rst = 1'b1;
        #1;
        chk("midrst_mvalid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        x0 = xfers;
        send(8'd0, 2'd3, 5'd7, 5'd8, 32'hE000_0001, 4'h9);
        drain();
        chk("midrst_words", xfers - x0, 1);

        s_valid1 = 1'b1; s_len1 = 8'd0; s_cmd1 = 2'd2; s_did1 = 6'h2A; s_sid1 = 6'h15;
        s_datax1 = 64'h0123_4567_89AB_CDEF; s_strb1 = 8'hA5;
        @(negedge clk);
        chk("w8_sready", s_ready1, 1);
        @(posedge clk);
        #1;
        s_valid1 = 1'b0;
        @(negedge clk);
        chk("w8_mvalid", m_valid1, 1);
        chk("w8_datax", m_data1[87:24], 64'h0123_4567_89AB_CDEF);
        chk("w8_strb", m_data1[23:16], 8'hA5);
        chk("w8_cmd", m_data1[15:14], 2'd2);
        chk("w8_did", m_data1[13:8], 6'h2A);
        chk("w8_sid", m_data1[7:2], 6'h15);
        chk("w8_first", m_data1[1], 1);
        chk("w8_last", m_data1[0], 1);
        chk("w8_busy", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
